// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences IF/ID/EX/MEM/WB and decodes datapath controls from state, opcode and funct.
// Latency: J 2, BEQ 3, R/ADDI/ORI/SW 4, LW 5 cycles; each mem wait or stall cycle adds one.
// Backpressure: stall freezes the state and masks every write/retire strobe; MEM optionally waits for mem_ready.
module mc_control_fsm #(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALU_OP_W  = 4,
  parameter int CNT_W     = 16,
  parameter bit MEM_HS_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                stall,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_dst_flag,
  output logic                alu_src_flag,
  output logic                mem_to_reg_flag,
  output logic                reg_write_flag,
  output logic                mem_read_flag,
  output logic                mem_write_flag,
  output logic                branch_flag,
  output logic                jump_flag,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_flag,
  output logic                instr_retired,
  output logic [CNT_W-1:0]    retire_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);

  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0110);
  localparam logic [ALU_OP_W-1:0] ALU_DEF = ALU_OP_W'(4'b1111);

  state_t             state_q, state_d;
  logic               illegal_q, illegal_set;
  logic [CNT_W-1:0]   cnt_q;

  logic is_r, is_j, is_beq, is_addi, is_ori, is_lw, is_sw;
  logic funct_ok;
  logic [ALU_OP_W-1:0] r_alu;
  logic state_valid;

  assign is_r    = (opcode == OP_R);
  assign is_j    = (opcode == OP_J);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_addi = (opcode == OP_ADDI);
  assign is_ori  = (opcode == OP_ORI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);

  // R-type funct to ALU operation; unknown funct marks the instruction illegal
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_DEF;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      default: funct_ok = 1'b0;
    endcase
  end

  // Next-state and control decode; stall masking applied last so it overrides every state
  always_comb begin
    state_d         = state_q;
    illegal_set     = 1'b0;
    state_valid     = 1'b1;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    reg_dst_flag    = 1'b0;
    alu_src_flag    = 1'b0;
    mem_to_reg_flag = 1'b0;
    reg_write_flag  = 1'b0;
    mem_read_flag   = 1'b0;
    mem_write_flag  = 1'b0;
    branch_flag     = 1'b0;
    jump_flag       = 1'b0;
    alu_op          = ALU_DEF;
    instr_retired   = 1'b0;

    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          jump_flag     = 1'b1;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
          state_d       = S_IF;
        end else if ((is_r && funct_ok) || is_beq || is_addi || is_ori || is_lw || is_sw) begin
          state_d = S_EX;
        end else begin
          illegal_set = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_EX: begin
        if (is_r) begin
          reg_dst_flag = 1'b1;
          alu_op       = r_alu;
          state_d      = S_WB;
        end else if (is_addi || is_ori) begin
          alu_src_flag = 1'b1;
          alu_op       = is_ori ? ALU_OR : ALU_ADD;
          state_d      = S_WB;
        end else if (is_beq) begin
          branch_flag   = 1'b1;
          alu_op        = ALU_SUB;
          instr_retired = 1'b1;
          state_d       = S_IF;
        end else if (is_lw || is_sw) begin
          alu_src_flag = 1'b1;
          alu_op       = ALU_ADD;
          state_d      = S_MEM;
        end else begin
          // opcode changed under us; restart fetch rather than wedge
          state_d = S_IF;
        end
      end
      S_MEM: begin
        mem_read_flag  = is_lw;
        mem_write_flag = is_sw;
        if (!MEM_HS_EN || mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            instr_retired = is_sw;
            state_d       = S_IF;
          end
        end
      end
      S_WB: begin
        reg_write_flag  = 1'b1;
        mem_to_reg_flag = is_lw;
        instr_retired   = 1'b1;
        state_d         = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        // unused encodings recover to fetch even while stalled
        state_valid = 1'b0;
        state_d     = S_IF;
      end
    endcase

    if (stall && state_valid) begin
      state_d        = state_q;
      illegal_set    = 1'b0;
      ir_write       = 1'b0;
      pc_write       = 1'b0;
      reg_write_flag = 1'b0;
      mem_write_flag = 1'b0;
      instr_retired  = 1'b0;
    end
  end

  // State register, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (instr_retired) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state        = state_q;
  assign illegal_flag = illegal_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: table of per-cycle vectors plus hand sequences for halt, async reset and counter wrap.
// A second instance (CNT_W=2, no memory handshake) shares the stimulus.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100, FN_OR = 6'b100101;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  // expected-control bit positions: {ir,pc,rdst,asrc,m2r,rw,mr,mw,br,jmp,ill,ret,alu[3:0]}
  localparam logic [15:0] IRW = 16'h8000, PCW = 16'h4000, RDST = 16'h2000, ASRC = 16'h1000;
  localparam logic [15:0] M2R = 16'h0800, RW = 16'h0400, MR = 16'h0200, MW = 16'h0100;
  localparam logic [15:0] BR = 16'h0080, JMP = 16'h0040, ILL = 16'h0020, RET = 16'h0010;
  localparam logic [15:0] A_AND = 16'h0000, A_OR = 16'h0001, A_ADD = 16'h0002, A_SUB = 16'h0006, A_DEF = 16'h000F;
  localparam logic [15:0] FETCH = IRW | PCW | A_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       stall, mem_ready;

  logic [2:0]  state_a, state_b;
  logic        ir_a, pc_a, rdst_a, asrc_a, m2r_a, rw_a, mr_a, mw_a, br_a, jmp_a, ill_a, ret_a;
  logic        ir_b, pc_b, rdst_b, asrc_b, m2r_b, rw_b, mr_b, mw_b, br_b, jmp_b, ill_b, ret_b;
  logic [3:0]  alu_a, alu_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] ctl_a, ctl_b;

  assign ctl_a = {ir_a, pc_a, rdst_a, asrc_a, m2r_a, rw_a, mr_a, mw_a, br_a, jmp_a, ill_a, ret_a, alu_a};
  assign ctl_b = {ir_b, pc_b, rdst_b, asrc_b, m2r_b, rw_b, mr_b, mw_b, br_b, jmp_b, ill_b, ret_b, alu_b};

  mc_control_fsm dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .stall(stall), .mem_ready(mem_ready),
    .state(state_a), .ir_write(ir_a), .pc_write(pc_a), .reg_dst_flag(rdst_a), .alu_src_flag(asrc_a),
    .mem_to_reg_flag(m2r_a), .reg_write_flag(rw_a), .mem_read_flag(mr_a), .mem_write_flag(mw_a),
    .branch_flag(br_a), .jump_flag(jmp_a), .alu_op(alu_a), .illegal_flag(ill_a),
    .instr_retired(ret_a), .retire_count(cnt_a)
  );

  mc_control_fsm #(.CNT_W(2), .MEM_HS_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .stall(stall), .mem_ready(mem_ready),
    .state(state_b), .ir_write(ir_b), .pc_write(pc_b), .reg_dst_flag(rdst_b), .alu_src_flag(asrc_b),
    .mem_to_reg_flag(m2r_b), .reg_write_flag(rw_b), .mem_read_flag(mr_b), .mem_write_flag(mw_b),
    .branch_flag(br_b), .jump_flag(jmp_b), .alu_op(alu_b), .illegal_flag(ill_b),
    .instr_retired(ret_b), .retire_count(cnt_b)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        stl;
    logic        rdy;
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic stl, input logic rdy,
                              input logic [2:0] st, input logic [15:0] ctl, input logic [15:0] cnt);
    vec_t v;
    v.op = op; v.fn = fn; v.stl = stl; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // drive one cycle of inputs, check on the falling edge, then take the rising edge
  task automatic run_vec(input vec_t v, input int idx);
    opcode = v.op; funct = v.fn; stall = v.stl; mem_ready = v.rdy;
    @(negedge clk);
    chk($sformatf("v%0d state", idx), {13'd0, state_a}, {13'd0, v.st});
    chk($sformatf("v%0d ctl", idx), ctl_a, v.ctl);
    chk($sformatf("v%0d count", idx), cnt_a, v.cnt);
    @(posedge clk);
    #1;
  endtask

  // asynchronous reset pulse between clock edges
  task automatic async_reset(input string nm, input logic [15:0] cnt_before);
    stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk({nm, " pre-reset count"}, cnt_before, cnt_before);
    chk({nm, " state"}, {13'd0, state_a}, {13'd0, S_IF});
    chk({nm, " illegal"}, {15'd0, ill_a}, 16'd0);
    chk({nm, " count"}, cnt_a, 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [1:0] exp_b [5];
  logic [2:0] seq_st [4];

  initial begin
    exp_b  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    seq_st = '{S_IF, S_ID, S_EX, S_WB};

    // ADD
    vecs.push_back(mk(OP_R, FN_ADD, 0, 0, S_IF, FETCH, 0));
    vecs.push_back(mk(OP_R, FN_ADD, 0, 0, S_ID, A_DEF, 0));
    vecs.push_back(mk(OP_R, FN_ADD, 0, 0, S_EX, RDST | A_ADD, 0));
    vecs.push_back(mk(OP_R, FN_ADD, 0, 0, S_WB, RW | RET | A_DEF, 0));
    // LW with three wait cycles
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_IF, FETCH, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_ID, A_DEF, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_EX, ASRC | A_ADD, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_MEM, MR | A_DEF, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_MEM, MR | A_DEF, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_MEM, MR | A_DEF, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 1, S_MEM, MR | A_DEF, 1));
    vecs.push_back(mk(OP_LW, FN_ADD, 0, 0, S_WB, RW | M2R | RET | A_DEF, 1));
    // J then BEQ
    vecs.push_back(mk(OP_J, FN_ADD, 0, 0, S_IF, FETCH, 2));
    vecs.push_back(mk(OP_J, FN_ADD, 0, 0, S_ID, JMP | PCW | RET | A_DEF, 2));
    vecs.push_back(mk(OP_BEQ, FN_ADD, 0, 0, S_IF, FETCH, 3));
    vecs.push_back(mk(OP_BEQ, FN_ADD, 0, 0, S_ID, A_DEF, 3));
    vecs.push_back(mk(OP_BEQ, FN_ADD, 0, 0, S_EX, BR | RET | A_SUB, 3));
    // SW stalled two cycles in MEM with mem_ready high
    vecs.push_back(mk(OP_SW, FN_ADD, 0, 1, S_IF, FETCH, 4));
    vecs.push_back(mk(OP_SW, FN_ADD, 0, 1, S_ID, A_DEF, 4));
    vecs.push_back(mk(OP_SW, FN_ADD, 0, 1, S_EX, ASRC | A_ADD, 4));
    vecs.push_back(mk(OP_SW, FN_ADD, 1, 1, S_MEM, A_DEF, 4));
    vecs.push_back(mk(OP_SW, FN_ADD, 1, 1, S_MEM, A_DEF, 4));
    vecs.push_back(mk(OP_SW, FN_ADD, 0, 1, S_MEM, MW | RET | A_DEF, 4));
    // ORI
    vecs.push_back(mk(OP_ORI, FN_ADD, 0, 0, S_IF, FETCH, 5));
    vecs.push_back(mk(OP_ORI, FN_ADD, 0, 0, S_ID, A_DEF, 5));
    vecs.push_back(mk(OP_ORI, FN_ADD, 0, 0, S_EX, ASRC | A_OR, 5));
    vecs.push_back(mk(OP_ORI, FN_ADD, 0, 0, S_WB, RW | RET | A_DEF, 5));
    // ADDI with a stall in IF and in WB
    vecs.push_back(mk(OP_ADDI, FN_ADD, 1, 0, S_IF, A_DEF, 6));
    vecs.push_back(mk(OP_ADDI, FN_ADD, 0, 0, S_IF, FETCH, 6));
    vecs.push_back(mk(OP_ADDI, FN_ADD, 0, 0, S_ID, A_DEF, 6));
    vecs.push_back(mk(OP_ADDI, FN_ADD, 0, 0, S_EX, ASRC | A_ADD, 6));
    vecs.push_back(mk(OP_ADDI, FN_ADD, 1, 0, S_WB, A_DEF, 6));
    vecs.push_back(mk(OP_ADDI, FN_ADD, 0, 0, S_WB, RW | RET | A_DEF, 6));
    // SUB, AND, OR
    vecs.push_back(mk(OP_R, FN_SUB, 0, 0, S_IF, FETCH, 7));
    vecs.push_back(mk(OP_R, FN_SUB, 0, 0, S_ID, A_DEF, 7));
    vecs.push_back(mk(OP_R, FN_SUB, 0, 0, S_EX, RDST | A_SUB, 7));
    vecs.push_back(mk(OP_R, FN_SUB, 0, 0, S_WB, RW | RET | A_DEF, 7));
    vecs.push_back(mk(OP_R, FN_AND, 0, 0, S_IF, FETCH, 8));
    vecs.push_back(mk(OP_R, FN_AND, 0, 0, S_ID, A_DEF, 8));
    vecs.push_back(mk(OP_R, FN_AND, 0, 0, S_EX, RDST | A_AND, 8));
    vecs.push_back(mk(OP_R, FN_AND, 0, 0, S_WB, RW | RET | A_DEF, 8));
    vecs.push_back(mk(OP_R, FN_OR, 0, 0, S_IF, FETCH, 9));
    vecs.push_back(mk(OP_R, FN_OR, 0, 0, S_ID, A_DEF, 9));
    vecs.push_back(mk(OP_R, FN_OR, 0, 0, S_EX, RDST | A_OR, 9));
    vecs.push_back(mk(OP_R, FN_OR, 0, 0, S_WB, RW | RET | A_DEF, 9));
    // R-type with unknown funct halts
    vecs.push_back(mk(OP_R, 6'b000001, 0, 0, S_IF, FETCH, 10));
    vecs.push_back(mk(OP_R, 6'b000001, 0, 0, S_ID, A_DEF, 10));
    vecs.push_back(mk(OP_R, 6'b000001, 0, 0, S_HALT, ILL | A_DEF, 10));

    // reset
    rst_n = 1'b0; opcode = OP_R; funct = FN_ADD; stall = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", {13'd0, state_a}, {13'd0, S_IF});
    chk("reset count", cnt_a, 16'd0);
    chk("reset illegal", {15'd0, ill_a}, 16'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // HALT persists for 10 cycles whatever the inputs
    for (int i = 0; i < 10; i++)
      run_vec(mk((i % 2) ? OP_J : OP_ADDI, FN_ADD, (i % 3) == 0, 1, S_HALT, ILL | A_DEF, 10), 100 + i);
    async_reset("halt reset", 16'd10);

    // illegal opcode 111111
    run_vec(mk(6'b111111, FN_ADD, 0, 0, S_IF, FETCH, 0), 200);
    run_vec(mk(6'b111111, FN_ADD, 0, 0, S_ID, A_DEF, 0), 201);
    for (int i = 0; i < 10; i++)
      run_vec(mk(6'b111111, FN_ADD, 0, 1, S_HALT, ILL | A_DEF, 0), 210 + i);
    async_reset("illegal reset", 16'd0);

    // async reset taken from MEM with a nonzero count
    run_vec(mk(OP_J, FN_ADD, 0, 0, S_IF, FETCH, 0), 300);
    run_vec(mk(OP_J, FN_ADD, 0, 0, S_ID, JMP | PCW | RET | A_DEF, 0), 301);
    run_vec(mk(OP_LW, FN_ADD, 0, 0, S_IF, FETCH, 1), 302);
    run_vec(mk(OP_LW, FN_ADD, 0, 0, S_ID, A_DEF, 1), 303);
    run_vec(mk(OP_LW, FN_ADD, 0, 0, S_EX, ASRC | A_ADD, 1), 304);
    run_vec(mk(OP_LW, FN_ADD, 0, 0, S_MEM, MR | A_DEF, 1), 305);
    chk("mem before reset", {13'd0, state_a}, {13'd0, S_MEM});
    async_reset("mem reset", 16'd1);

    // narrow counter wraps: five ADDI on the CNT_W=2 instance
    opcode = OP_ADDI; funct = FN_ADD; stall = 1'b0; mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        chk($sformatf("b addi%0d st%0d", k, s), {13'd0, state_b}, {13'd0, seq_st[s]});
        @(posedge clk);
        #1;
      end
      chk($sformatf("b count %0d", k), {14'd0, cnt_b}, {14'd0, exp_b[k]});
    end

    // SW without handshake: single MEM cycle even with mem_ready low
    opcode = OP_SW;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("b sw mem state", {13'd0, state_b}, {13'd0, S_MEM});
    chk("b sw mem ctl", ctl_b, MW | RET | A_DEF);
    @(posedge clk);
    #1;
    chk("b sw exit state", {13'd0, state_b}, {13'd0, S_IF});
    chk("b sw count", {14'd0, cnt_b}, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL provide these parameters:
- OPCODE_W, 6, opcode field width.
- FUNCT_W, 6, funct field width.
- ALU_OP_W, 4, ALU operation code width.
- CNT_W, 16, retired-instruction counter width.
- MEM_HS_EN, 1: 1 = MEM waits for mem_ready; 0 = MEM lasts exactly one cycle.

REQ-002 SHALL provide these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  instruction opcode from the instruction register.
- funct  in  FUNCT_W  instruction funct field.
- stall  in  1  freezes the FSM.
- mem_ready  in  1  data-memory access complete.
- state  out  3  current state.
- ir_write  out  1  instruction-register load enable.
- pc_write  out  1  unconditional PC update.
- reg_dst_flag, alu_src_flag, mem_to_reg_flag, reg_write_flag, mem_read_flag, mem_write_flag, branch_flag, jump_flag  out  1 each  datapath controls.
- alu_op  out  ALU_OP_W  ALU operation.
- illegal_flag  out  1  sticky illegal-instruction flag.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- retire_count  out  CNT_W  completed-instruction count.

Function
REQ-003 State encoding SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to IF on the next edge.
REQ-004 Opcodes SHALL be R=000000, J=000010, BEQ=000100, ADDI=001000, ORI=001101, LW=100011, SW=101011.
REQ-005 R-type funct codes SHALL be ADD=100000, SUB=100010, AND=100100, OR=100101.
REQ-006 alu_op SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110, DEFAULT=1111.
REQ-007 The state register SHALL be registered; all control outputs SHALL be combinational decodes of state, opcode and funct.
REQ-008 Every control output not listed for the current state SHALL be 0; alu_op SHALL be DEFAULT.
REQ-009 IF: ir_write=1 and pc_write=1; next state ID.
REQ-010 ID, opcode J: jump_flag=1, pc_write=1, instr_retired=1; next state IF.
REQ-011 ID, opcode not in REQ-004, or R-type with funct not in REQ-005: next state HALT and illegal_flag set; no retire.
REQ-012 ID, all other legal instructions: next state EX.
REQ-013 EX, R-type: reg_dst_flag=1, alu_op from funct; next state WB.
REQ-014 EX, ADDI/ORI: alu_src_flag=1, alu_op=ADD/OR; next state WB.
REQ-015 EX, BEQ: branch_flag=1, alu_op=SUB, instr_retired=1; next state IF.
REQ-016 EX, LW/SW: alu_src_flag=1, alu_op=ADD; next state MEM.
REQ-017 MEM: mem_read_flag=1 (LW) or mem_write_flag=1 (SW), held every MEM cycle.
- With MEM_HS_EN=1, MEM SHALL stay until mem_ready=1 is sampled.
- On exit: LW goes to WB; SW goes to IF with instr_retired=1 on the exit cycle.
REQ-018 WB: reg_write_flag=1; mem_to_reg_flag=1 only for LW; instr_retired=1; next state IF.
REQ-019 HALT: all control outputs 0; HALT SHALL persist until reset.
REQ-020 stall=1 SHALL hold state and force ir_write, pc_write, reg_write_flag, mem_write_flag and instr_retired to 0.
- stall takes priority over mem_ready.
REQ-021 retire_count SHALL increment by 1 on every edge where instr_retired=1, wrapping from 2^CNT_W-1 to 0.
REQ-022 Control-unit total latency SHALL be: J 2 cycles; BEQ 3; R/ADDI/ORI 4; SW 4; LW 5. Each MEM wait cycle and each stall cycle adds one.

Reset
REQ-023 rst_n=0 SHALL immediately, without a clock edge, set state=IF, illegal_flag=0 and retire_count=0.
- This holds mid-operation, including from MEM and HALT.
REQ-024 After rst_n deasserts, the first clk edge SHALL advance IF to ID, provided stall=0.

Verification
REQ-025 Reset, then ADD (opcode 000000, funct 100000), stall=0:
- state sequence 0,1,2,4,0;
- alu_op=0010 and reg_dst_flag=1 in EX;
- reg_write_flag=1 in WB;
- retire_count=1.
REQ-026 LW, MEM_HS_EN=1, mem_ready held low 3 cycles then high:
- 4 MEM cycles with mem_read_flag=1;
- then WB with mem_to_reg_flag=1;
- retire_count increments once.
REQ-027 J, then BEQ:
- J: jump_flag=1 in ID, returns to IF after 2 cycles;
- BEQ: branch_flag=1 and alu_op=0110 in EX;
- retire_count=2.
REQ-028 Opcode 111111:
- state 5 after ID, illegal_flag=1, all write enables 0 for 10 cycles;
- rst_n pulse clears to state 0, illegal_flag=0.
REQ-029 SW with stall=1 asserted 2 cycles in MEM, mem_ready=1:
- state holds 3 and mem_write_flag=0 while stalled;
- exits to IF after stall drops.
REQ-030 CNT_W=2, run 5 ADDI instructions: retire_count sequence 1,2,3,0,1.
